// File: rtl/gate_bist_pkg.sv
// Shared encodings for the gate BIST: expected-function opcodes and FSM states.
package gate_bist_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden 2-input gate: expected output for a given opcode and inputs.
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       z
);
  always_comb begin
    z = 1'b0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_NAND: z = ~(a & b);
      default: z = 1'b0;
    endcase
  end
endmodule

// File: rtl/gate_bist.sv
// Sweeps a 2-input gate through 00,01,10,11, holding each pattern HOLD_CYCLES
// cycles, and checks the sampled output against the selected truth table.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state, state_n;
  logic [1:0]    op_l, op_l_n;
  logic [1:0]    p, p_n;
  logic [HW-1:0] h, h_n;
  logic          x_n, y_n, busy_n, done_n, pass_n;
  logic [2:0]    err_n;
  logic [3:0]    fail_n;
  logic          exp_z;

  gate_ref_model u_ref (.op(op_l), .a(p[1]), .b(p[0]), .z(exp_z));

  always_comb begin
    state_n = state;
    op_l_n  = op_l;
    p_n     = p;
    h_n     = h;
    x_n     = x;
    y_n     = y;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    err_n   = err_count;
    fail_n  = fail_vec;
    case (state)
      IDLE: begin
        x_n = 1'b0;
        y_n = 1'b0;
        if (start) begin
          op_l_n  = op;
          pass_n  = 1'b0;
          err_n   = 3'd0;
          fail_n  = 4'd0;
          p_n     = 2'd0;
          h_n     = '0;
          busy_n  = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        h_n = h + 1'b1;
        if (h == H_LAST) begin
          if (z != exp_z) begin
            fail_n[p] = 1'b1;
            err_n     = err_count + 3'd1;
          end
          h_n = '0;
          if (p != 2'd3) begin
            p_n        = p + 2'd1;
            {x_n, y_n} = p + 2'd1;
          end else begin
            // pass must include the comparison made on this very edge
            p_n     = 2'd0;
            x_n     = 1'b0;
            y_n     = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == 3'd0);
            state_n = DONE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_l      <= 2'd0;
      p         <= 2'd0;
      h         <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      state     <= state_n;
      op_l      <= op_l_n;
      p         <= p_n;
      h         <= h_n;
      x         <= x_n;
      y         <= y_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end
endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench: two BIST instances (hold 10 and hold 1) each facing a
// gate modelled as a 4-entry truth table; results checked against a table model.
module tb_gate_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 0, start1 = 0;
  logic [1:0] op0 = 0, op1 = 0;
  logic [3:0] tt0 = 4'b1110, tt1 = 4'b1110;
  logic       x0, y0, z0, busy0, done0, pass0;
  logic       x1, y1, z1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fv0, fv1;

  assign z0 = tt0[{x0, y0}];
  assign z1 = tt1[{x1, y1}];

  gate_bist #(.HOLD_CYCLES(10)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .x(x0), .y(y0), .z(z0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0));

  gate_bist #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // truth table of each function, bit p = output for x=p[1], y=p[0]
  function automatic logic [3:0] truth(input logic [1:0] o);
    case (o)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b1110;
      2'b10:   return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic drive(input int s, input logic st, input logic [1:0] o);
    if (s != 0) begin start1 = st; op1 = o; end
    else        begin start0 = st; op0 = o; end
  endtask

  // Runs one sweep, checking the per-cycle waveform and the final result.
  task automatic sweep(input int s, input logic [1:0] o, input logic [3:0] tt,
                       input int mid, input logic [3:0] ef, input int ee,
                       input logic ep, input string nm);
    int hc = (s != 0) ? 1 : 10;
    logic [1:0] oc = o;
    logic bz, dn, xx, yy, ps;
    logic [2:0] er;
    logic [3:0] fv;
    @(negedge clk);
    if (s != 0) tt1 = tt; else tt0 = tt;
    drive(s, 1'b1, oc);
    for (int k = 1; k <= 4*hc + 2; k++) begin
      @(negedge clk);
      if (k == 1) drive(s, 1'b0, oc);
      if (k == mid) begin oc = ~oc; drive(s, 1'b1, oc); end
      if (k == mid + 1) drive(s, 1'b0, oc);
      if (s != 0) begin bz = busy1; dn = done1; xx = x1; yy = y1; ps = pass1; er = err1; fv = fv1; end
      else        begin bz = busy0; dn = done0; xx = x0; yy = y0; ps = pass0; er = err0; fv = fv0; end
      chk({nm, "/busy"}, int'(bz), int'(k <= 4*hc));
      chk({nm, "/done"}, int'(dn), int'(k == 4*hc + 1));
      chk({nm, "/xy"}, int'({xx, yy}), (k <= 4*hc) ? (k - 1) / hc : 0);
      if (k >= 4*hc + 1) begin
        chk({nm, "/fail_vec"}, int'(fv), int'(ef));
        chk({nm, "/err_count"}, int'(er), ee);
        chk({nm, "/pass"}, int'(ps), int'(ep));
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] tt;
    logic [3:0] ef;
    int         ee;
    logic       ep;
    string      nm;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   dcnt;
    tbl[0] = '{2'b01, 4'b1110, 4'b0000, 0, 1'b1, "or_ok"};
    tbl[1] = '{2'b01, 4'b0000, 4'b1110, 3, 1'b0, "or_stuck0"};
    tbl[2] = '{2'b00, 4'b1110, 4'b0110, 2, 1'b0, "and_vs_or"};
    tbl[3] = '{2'b11, 4'b1000, 4'b1111, 4, 1'b0, "nand_vs_and"};
    tbl[4] = '{2'b10, 4'b0110, 4'b0000, 0, 1'b1, "xor_ok"};

    repeat (3) @(negedge clk);
    chk("rst/x", int'(x0), 0);
    chk("rst/busy", int'(busy0), 0);
    chk("rst/done", int'(done0), 0);
    chk("rst/results", int'({pass0, err0, fv0}), 0);
    chk("rst1/results", int'({busy1, pass1, err1, fv1}), 0);
    rst = 1'b0;

    foreach (tbl[i]) sweep(0, tbl[i].op, tbl[i].tt, 0, tbl[i].ef, tbl[i].ee, tbl[i].ep, tbl[i].nm);

    // start pulsed mid-sweep with a different op must not disturb the run
    sweep(0, 2'b01, 4'b1110, 20, 4'b0000, 0, 1'b1, "mid_start");

    // hold of one cycle
    sweep(1, 2'b01, 4'b1110, 0, 4'b0000, 0, 1'b1, "hold1_or");
    sweep(1, 2'b00, 4'b1110, 0, 4'b0110, 2, 1'b0, "hold1_and");

    // reset 15 cycles into a sweep that has already logged a mismatch
    @(negedge clk);
    tt0 = 4'b0000;
    drive(0, 1'b1, 2'b11);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b0, 2'b11);
    end
    chk("pre_rst/err_count", int'(err0), 1);
    chk("pre_rst/fail_vec", int'(fv0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/xy", int'({x0, y0}), 0);
    chk("abort/busy", int'(busy0), 0);
    chk("abort/results", int'({pass0, err0, fv0}), 0);
    dcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done0 || busy0) dcnt++;
    end
    chk("abort/no_done", dcnt, 0);
    sweep(0, 2'b01, 4'b1110, 0, 4'b0000, 0, 1'b1, "after_abort");

    // randomized sweeps against the truth-table model
    for (int i = 0; i < 24; i++) begin
      int         s  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      logic [1:0] o  = 2'($urandom);
      logic [3:0] tt = 4'($urandom);
      logic [3:0] ef = tt ^ truth(o);
      sweep(s, o, tt, 0, ef, popc(ef), ef == 4'd0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_bist.md
# gate_bist

Synthesizable stimulus-and-check engine for a 2-input logic gate. It is the hardware counterpart of a gate testbench.
- On `start`, it drives the gate's `x`/`y` inputs through the four input combinations 00, 01, 10, 11, holding each for a programmable number of cycles.
- It samples the gate output `z` and compares it against the expected truth table for a selected gate function.
- It reports per-pattern failures, an error count and a pass flag.

It sits beside a single gate instance (orgate or similar) in the Day-series labs and replaces the manual `$monitor` inspection with on-chip checking.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: cycles each input pattern is held. Legal values are ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a sweep. Accepted only in IDLE.
- `op`, in, 2: expected gate function. 00 AND, 01 OR, 10 XOR, 11 NAND. Latched when `start` is accepted.
- `x`, out, 1: gate input A stimulus.
- `y`, out, 1: gate input B stimulus.
- `z`, in, 1: gate output under test. Treated as combinationally settled from registered `x`/`y`.
- `busy`, out, 1: high while a sweep is in progress.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `pass`, out, 1: 1 when the last sweep had zero mismatches. Holds until the next accepted `start`.
- `err_count`, out, 3: number of mismatching patterns (0..4). Holds until the next accepted `start`.
- `fail_vec`, out, 4: bit p set when pattern p (x=p[1], y=p[0]) mismatched. Holds until the next accepted `start`.

## Operation
- Reset values: `x`=0, `y`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0. The FSM resets to IDLE with the pattern index and hold counter at 0.
- FSM states are IDLE, DRIVE, DONE.
- **IDLE:**
  - If `start`=1: latch `op`, clear `pass`/`err_count`/`fail_vec`, set pattern p=0 and hold counter h=0, drive `x`/`y` from p, assert `busy`, and go to DRIVE.
  - If `start`=0: `x`/`y` stay 0.
- **DRIVE:**
  - Increment h each cycle.
  - On the cycle where h==HOLD_CYCLES-1, sample `z` and compare it with expected(op_latched, p[1], p[0]).
    - On mismatch, set `fail_vec[p]` and increment `err_count`.
  - If p<3: set p←p+1, h←0, and update `x`/`y` on the same edge.
  - If p==3: go to DONE.
- **DONE** lasts one cycle:
  - `done`=1, `busy`=0, `x`/`y` return to 0.
  - `pass`=(err_count==0), evaluated with the final comparison included.
  - Next state is IDLE.
- `start` is ignored in DRIVE and DONE; it is not queued.
- `op` changes after acceptance have no effect on the running sweep.
- Reset mid-sweep aborts immediately:
  - Reset values apply on the reset edge.
  - No `done` pulse is generated.
  - Previous result registers are cleared.
- `rst` and `start` in the same cycle: `rst` wins.
- Counter widths:
  - h is `$clog2(HOLD_CYCLES)` bits, minimum 1 bit.
  - `err_count` cannot overflow, since its maximum is 4.

## Timing
- Start is accepted at edge E0. Pattern p is driven on cycles E0+1+p·HOLD_CYCLES through E0+(p+1)·HOLD_CYCLES.
- `z` for pattern p is sampled at edge E0+(p+1)·HOLD_CYCLES.
- `done` is high during the cycle after edge E0+4·HOLD_CYCLES, with `pass` valid from that same cycle.
- `busy` is high for exactly 4·HOLD_CYCLES cycles.
- A new `start` is accepted as early as the cycle after `done`.
- Total start-to-done latency is 4·HOLD_CYCLES+1 cycles.

## Structure
- Package `gate_bist_pkg`:
  - `op` encodings as localparams: OP_AND, OP_OR, OP_XOR, OP_NAND.
  - FSM state typedef (IDLE, DRIVE, DONE).
- Sub-module `gate_ref_model`: combinational expected-output function of (op, a, b), reusable by later gate labs.
- Everything else stays in `gate_bist`.

## Test plan
All scenarios use HOLD_CYCLES=10 unless stated.
- OR gate DUT, `op`=01, pulse `start` → `x,y` sequence 00,01,10,11 at 10 cycles each; `done` 41 cycles after start; `pass`=1, `err_count`=0, `fail_vec`=0000.
- `z` tied to 0, `op`=01 → `fail_vec`=4'b1110, `err_count`=3, `pass`=0.
- OR gate DUT, `op`=00 (AND expected) → mismatches on 01 and 10; `fail_vec`=4'b0110, `err_count`=2, `pass`=0.
- Assert `rst` 15 cycles into a sweep → next cycle `x`=`y`=0, `busy`=0, all results 0; no `done` pulse. A subsequent `start` runs a full clean sweep.
- Pulse `start` again at cycle 20 of a sweep and toggle `op` → ignored; single `done` at cycle 41; results reflect the original `op`.
- HOLD_CYCLES=1, OR DUT, `op`=01 → `busy` high 4 cycles, patterns change every cycle; `done` at cycle 5; `pass`=1.
